bus_port_fifo: RTL and testbench
================================

BUS_PORT_FIFO -- requirements
Module: bus_port_fifo

Interface
REQ-001 SHALL have parameter pckg_sz, default 16, packet width in bits.
REQ-002 SHALL have parameter depth, default 8, TX FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter id, default 8'h00, this port's 8-bit address.
REQ-004 SHALL have parameter broadcast, default {8{1'b1}}, broadcast address.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port wr_en, input, 1, device-side write strobe.
REQ-008 SHALL have port wr_data, input, pckg_sz, device-side packet.
REQ-009 SHALL have port full, output, 1, TX FIFO full.
REQ-010 SHALL have port pndng, output, 1, TX FIFO non-empty; goes to the bus arbiter.
REQ-011 SHALL have port D_pop, output, pckg_sz, TX FIFO head; goes to the bus.
REQ-012 SHALL have port pop, input, 1, bus consumed the head.
REQ-013 SHALL have port push, input, 1, bus delivers a packet.
REQ-014 SHALL have port D_push, input, pckg_sz, delivered packet; destination is bits [pckg_sz-1 -: 8].
REQ-015 SHALL have port rx_valid, output, 1, one-cycle pulse for an accepted packet.
REQ-016 SHALL have port rx_data, output, pckg_sz, accepted packet.
REQ-017 SHALL have port err, output, 2, sticky {overflow, underflow}.

Function
REQ-018 SHALL implement the TX FIFO as show-ahead: D_pop shows the head whenever pndng=1.
REQ-019 SHALL raise pndng and present a word on D_pop one cycle after wr_en on an empty FIFO.
REQ-020 SHALL advance the head on pop while pndng=1; the new head is valid on the next cycle.
REQ-021 SHALL drive full when count==depth and pndng when count!=0; count width is $clog2(depth)+1.
REQ-022 SHALL wrap read and write pointers modulo depth without a bubble.
REQ-023 SHALL drop wr_en while full and pop is low, and set err[1].
REQ-024 SHALL, on wr_en and pop both high while full, accept both; count stays at depth.
REQ-025 SHALL ignore pop while empty and set err[0]; a simultaneous wr_en is still written.
REQ-026 SHALL accept push when the D_push destination equals id or broadcast.
REQ-027 SHALL register an accepted packet onto rx_data and pulse rx_valid exactly one cycle after push.
REQ-028 SHALL discard non-matching push with no rx_valid; rx_data holds its last value.
REQ-029 SHALL hold err bits until reset.

Reset
REQ-030 SHALL, while reset=0, force pointers and count to 0, pndng=0, full=0, D_pop=0, rx_valid=0, rx_data=0, err=0, and counters to 0.
REQ-031 SHALL lose FIFO contents when reset asserts mid-operation; the first post-reset write behaves as on an empty FIFO.

Configuration
REQ-032 SHALL, with BUS_PORT_STATS_EN defined, add 16-bit saturating outputs tx_cnt (pops), rx_cnt (accepted pushes) and drop_cnt (filtered pushes plus overflows).
REQ-033 SHALL, without BUS_PORT_STATS_EN, omit those ports and their logic; all other behaviour is unchanged.

Structure
REQ-034 SHALL put the address-field width (8), the default broadcast value and the err bit indices in the shared package.
REQ-035 SHALL place the TX storage in sub-module bus_port_fifo_mem (depth x pckg_sz, 1W1R, asynchronous read).

Verification
REQ-036 SHALL test: reset, then write 16'hA001 -> next cycle pndng=1, D_pop=16'hA001.
REQ-037 SHALL test: write 8 words with depth 8, then a ninth -> full=1, ninth dropped, err=2'b10; popping returns all 8 in order.
REQ-038 SHALL test: full FIFO with wr_en+pop together -> count stays 8 and the new word exits last.
REQ-039 SHALL test: pop on empty -> err=2'b01, pndng stays 0.
REQ-040 SHALL test: id=8'h02; push 16'h02BE, 16'hFF11, 16'h0333 -> rx_valid for the first two only; rx_data=16'h02BE then 16'hFF11.
REQ-041 SHALL test: drive reset low with 3 words queued -> pndng=0 at once; after release, a write of 16'h0555 appears at D_pop next cycle.

Source files
------------

// File: rtl/bus_port_fifo_pkg.sv
// rtl/bus_port_fifo_pkg.sv - shared constants and helpers for the bus port FIFO
package bus_port_fifo_pkg;

  localparam int ADDR_W = 8;
  localparam logic [ADDR_W-1:0] BCAST_ADDR = {ADDR_W{1'b1}};

  localparam int ERR_OVF = 1;
  localparam int ERR_UDF = 0;

  localparam int STAT_W = 16;

  // Saturating add of a 0..3 increment onto a statistics counter.
  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] v,
                                                input logic [1:0] inc);
    logic [STAT_W:0] s;
    s = {1'b0, v} + {{(STAT_W-1){1'b0}}, inc};
    return s[STAT_W] ? {STAT_W{1'b1}} : s[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/bus_port_fifo_mem.sv
// rtl/bus_port_fifo_mem.sv - TX storage, depth x pckg_sz, 1W1R, asynchronous read
module bus_port_fifo_mem #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8,
  parameter int aw      = $clog2(depth)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [aw-1:0]      waddr,
  input  logic [pckg_sz-1:0] wdata,
  input  logic [aw-1:0]      raddr,
  output logic [pckg_sz-1:0] rdata
);

  logic [pckg_sz-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_port_fifo.sv
// rtl/bus_port_fifo.sv - bus port: show-ahead TX FIFO plus address-filtered RX; BUS_PORT_STATS_EN adds counters
module bus_port_fifo
  import bus_port_fifo_pkg::*;
#(
  parameter int                pckg_sz   = 16,
  parameter int                depth     = 8,
  parameter logic [ADDR_W-1:0] id        = 8'h00,
  parameter logic [ADDR_W-1:0] broadcast = BCAST_ADDR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [pckg_sz-1:0] wr_data,
  output logic               full,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  output logic [1:0]         err
`ifdef BUS_PORT_STATS_EN
  ,
  output logic [STAT_W-1:0]  tx_cnt,
  output logic [STAT_W-1:0]  rx_cnt,
  output logic [STAT_W-1:0]  drop_cnt
`endif
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic [pckg_sz-1:0] head;
  logic               do_wr, do_pop, ovf, udf;
  logic [ADDR_W-1:0]  dest;
  logic               hit;

  assign full  = (count == CW'(depth));
  assign pndng = (count != '0);

  // When full, a simultaneous pop frees the slot the write lands in.
  assign do_pop = pop & pndng;
  assign do_wr  = wr_en & (~full | pop);
  assign ovf    = wr_en & full & ~pop;
  assign udf    = pop & ~pndng;

  bus_port_fifo_mem #(.pckg_sz(pckg_sz), .depth(depth), .aw(AW)) u_mem (
    .clk   (clk),
    .we    (do_wr),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign D_pop = pndng ? head : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= '0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count        <= count + CW'(do_wr) - CW'(do_pop);
      err[ERR_OVF] <= err[ERR_OVF] | ovf;
      err[ERR_UDF] <= err[ERR_UDF] | udf;
    end
  end

  assign dest = D_push[pckg_sz-1 -: ADDR_W];
  assign hit  = push & ((dest == id) | (dest == broadcast));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= hit;
      if (hit) rx_data <= D_push;
    end
  end

`ifdef BUS_PORT_STATS_EN
  logic [1:0] drop_inc;
  assign drop_inc = {1'b0, push & ~hit} + {1'b0, ovf};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      tx_cnt   <= sat_add(tx_cnt, {1'b0, do_pop});
      rx_cnt   <= sat_add(rx_cnt, {1'b0, hit});
      drop_cnt <= sat_add(drop_cnt, drop_inc);
    end
  end
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_bus_port_fifo.sv
// tb/tb_bus_port_fifo.sv - directed vector bench for bus_port_fifo
module tb_bus_port_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        full, pndng;
  logic [15:0] D_pop;
  logic        pop = 1'b0;
  logic        push = 1'b0;
  logic [15:0] D_push = '0;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic [1:0]  err;
`ifdef BUS_PORT_STATS_EN
  logic [15:0] tx_cnt, rx_cnt, drop_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  bus_port_fifo #(.pckg_sz(16), .depth(8), .id(8'h02), .broadcast(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .err      (err)
`ifdef BUS_PORT_STATS_EN
    ,
    .tx_cnt   (tx_cnt),
    .rx_cnt   (rx_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [15:0] wr_data;
    logic        pop;
    logic        push;
    logic [15:0] d_push;
    logic        e_pndng;
    logic        e_full;
    logic [15:0] e_dpop;
    logic        e_rxv;
    logic [15:0] e_rxd;
    logic [1:0]  e_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [15:0] d, input logic p);
    wr_en = w; wr_data = d; pop = p;
    @(posedge clk); #1;
    wr_en = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset();
    wr_en = 1'b0; pop = 1'b0; push = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'hA001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hA001, 1'b0, 16'h0000, 2'b00};
    vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'b00};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h02BE, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h02BE, 2'b00};
    vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hFF11, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFF11, 2'b00};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0333, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hFF11, 2'b00};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hFF11, 2'b00};
    vecs[6]  = '{1'b1, 16'hB002, 1'b0, 1'b1, 16'h0244, 1'b1, 1'b0, 16'hB002, 1'b1, 16'h0244, 2'b00};
    vecs[7]  = '{1'b1, 16'hB003, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hB002, 1'b0, 16'h0244, 2'b00};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hB003, 1'b0, 16'h0244, 2'b00};
    vecs[9]  = '{1'b1, 16'hB004, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hB004, 1'b0, 16'h0244, 2'b00};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0244, 2'b00};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0244, 2'b01};
    vecs[12] = '{1'b1, 16'hF00F, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hF00F, 1'b0, 16'h0244, 2'b01};
    vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0244, 2'b01};

    // Reset state, sampled while reset is held low.
    @(negedge clk);
    chk("rst_pndng", 32'(pndng), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_dpop", 32'(D_pop), 32'h0);
    chk("rst_rxv", 32'(rx_valid), 32'h0);
    chk("rst_rxd", 32'(rx_data), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data; pop = vecs[i].pop;
      push = vecs[i].push; D_push = vecs[i].d_push;
      @(posedge clk); #1;
      wr_en = 1'b0; pop = 1'b0; push = 1'b0;
      chk($sformatf("v%0d_pndng", i), 32'(pndng), 32'(vecs[i].e_pndng));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_full));
      chk($sformatf("v%0d_dpop", i), 32'(D_pop), 32'(vecs[i].e_dpop));
      chk($sformatf("v%0d_rxv", i), 32'(rx_valid), 32'(vecs[i].e_rxv));
      chk($sformatf("v%0d_rxd", i), 32'(rx_data), 32'(vecs[i].e_rxd));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e_err));
    end

    // Fill to depth, overflow, then drain in order.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk("fill_notfull", 32'(full), 32'h0);
      cyc(1'b1, 16'hC000 + 16'(i), 1'b0);
    end
    chk("fill_full", 32'(full), 32'h1);
    cyc(1'b1, 16'hC0FF, 1'b0);
    chk("ovf_full", 32'(full), 32'h1);
    chk("ovf_err", 32'(err), 32'h2);
    for (int i = 0; i < 8; i++) begin
      chk("drain_dpop", 32'(D_pop), 32'(16'hC000 + 16'(i)));
      cyc(1'b0, 16'h0, 1'b1);
    end
    chk("drain_pndng", 32'(pndng), 32'h0);
    chk("drain_err", 32'(err), 32'h2);

    // Full FIFO with simultaneous write and pop.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'hD000 + 16'(i), 1'b0);
    cyc(1'b1, 16'hE000, 1'b1);
    chk("both_full", 32'(full), 32'h1);
    chk("both_err", 32'(err), 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk("both_dpop", 32'(D_pop), (i < 7) ? 32'(16'hD001 + 16'(i)) : 32'hE000);
      cyc(1'b0, 16'h0, 1'b1);
    end
    chk("both_empty", 32'(pndng), 32'h0);

    // Reset asserted with words queued.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0100 + 16'(i), 1'b0);
    chk("q3_pndng", 32'(pndng), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_pndng", 32'(pndng), 32'h0);
    chk("midrst_dpop", 32'(D_pop), 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    cyc(1'b1, 16'h0555, 1'b0);
    chk("post_pndng", 32'(pndng), 32'h1);
    chk("post_dpop", 32'(D_pop), 32'h0555);
    cyc(1'b0, 16'h0, 1'b1);
    chk("post_empty", 32'(pndng), 32'h0);
    chk("post_err", 32'(err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
